aes_key_schedule_seq: RTL and testbench

- Iterative AES-128 key expansion (FIPS-197 §5.2). Produces round keys 0..10, one per handshake, as 128-bit words.
- Sits beside the round datapath. It feeds the AddRoundKey stage that consumes the MixColumns output, in lock-step with the round counter.
- Uses the same column-major byte packing as the state bus: byte s00 at [127:120], s10 at [119:112], and so on. Word w0 is [127:96].

---
 rtl/aes_key_schedule_seq_if.sv | 21 ++
 rtl/aes_key_schedule_seq.sv | 119 +++++++++++
 tb/tb_aes_key_schedule_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_seq_if.sv
// rtl/aes_key_schedule_seq_if.sv - start/round-key handshake bundle for the AES-128 key schedule
interface aes_key_schedule_seq_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_round, done
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// rtl/aes_key_schedule_seq.sv - iterative AES-128 key expansion, one round key per accepted handshake
// Round keys use the state-bus packing: w0 = [127:96], byte s00 at [127:120].
module aes_key_schedule_seq (
  input  logic                          clk,
  input  logic                          rst,
  aes_key_schedule_seq_if.slave         bus
);

  typedef enum logic {st_idle, st_run} state_t;

  localparam logic [7:0] sbox_table [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sbox_table[b];
  endfunction

  state_t       state;
  state_t       state_next;
  logic [127:0] rk_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic         done_q;
  logic         accept;
  logic         last_round;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_next;

  assign accept     = bus.rk_valid & bus.rk_ready;
  assign last_round = (round_q == 4'd10);

  // Next round key, derived entirely from the key currently on display.
  assign w0        = rk_q[127:96];
  assign w1        = rk_q[95:64];
  assign w2        = rk_q[63:32];
  assign w3        = rk_q[31:0];
  assign rot_w3    = {w3[23:0], w3[31:24]};
  assign t         = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                      sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ {rcon_q, 24'h0};
  assign n0        = w0 ^ t;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) state <= st_idle;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      st_idle: if (bus.start)           state_next = st_run;
      st_run:  if (accept && last_round) state_next = st_idle;
      default:                          state_next = st_idle;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.rk_valid = 1'b0;
    if (state == st_run) begin
      bus.busy     = 1'b1;
      bus.rk_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == st_idle) begin
        if (bus.start) begin
          rk_q    <= bus.key_in;
          round_q <= '0;
          rcon_q  <= 8'h01;
        end
      end else if (accept) begin
        // Round 10 keeps its value on the bus after the sequence ends.
        if (last_round) begin
          done_q <= 1'b1;
        end else begin
          rk_q    <= {n0, n1, n2, n3};
          round_q <= round_q + 4'd1;
          rcon_q  <= rcon_next;
        end
      end
    end
  end

  assign bus.rk_out   = rk_q;
  assign bus.rk_round = round_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb/tb_aes_key_schedule_seq.sv - randomized check of the AES-128 key schedule against a FIPS-197 style model
module tb_aes_key_schedule_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_schedule_seq_if bus ();

  aes_key_schedule_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   ref_sbox [256];
  logic [7:0]   ref_rcon [1:10];
  logic [127:0] exp_rk   [0:10];
  logic [127:0] got_rk   [0:10];

  localparam logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_tables();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    ref_rcon[1] = 8'h01;
    for (int i = 2; i <= 10; i++) ref_rcon[i] = gf_mul(ref_rcon[i-1], 8'h02);
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {ref_sbox[v[31:24]], ref_sbox[v[23:16]], ref_sbox[v[15:8]], ref_sbox[v[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) temp = sub_word({temp[23:0], temp[31:24]}) ^ {ref_rcon[i/4], 24'h0};
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Walks one expansion to its done cycle; on return the done pulse is on the bus.
  task automatic run_seq(input logic [127:0] key, input int ready_pct,
                         input bit already_started, input bit inject_start);
    int idx    = 0;
    int cycles = 0;
    expand(key);
    if (!already_started) begin
      bus.start  = 1'b1;
      bus.key_in = key;
      step();
    end
    bus.start = 1'b0;
    while (idx <= 10 && cycles < 500) begin
      logic rdy;
      rdy          = ($urandom_range(99) < ready_pct);
      bus.rk_ready = rdy;
      bus.start    = inject_start && (idx == 4);
      bus.key_in   = inject_start ? ~key : key;
      check("rk_valid", 128'(bus.rk_valid), 128'd1);
      check("busy",     128'(bus.busy),     128'd1);
      check("done_early", 128'(bus.done),   128'd0);
      check($sformatf("rk_round[%0d]", idx), 128'(bus.rk_round), 128'(idx));
      check($sformatf("rk_out[%0d]", idx), bus.rk_out, exp_rk[idx]);
      if (rdy) got_rk[idx] = bus.rk_out;
      step();
      cycles++;
      if (rdy) idx++;
    end
    bus.start = 1'b0;
    check("seq_timeout", 128'(cycles < 500), 128'd1);
    check("done_pulse",  128'(bus.done),     128'd1);
    check("valid_end",   128'(bus.rk_valid), 128'd0);
    check("busy_end",    128'(bus.busy),     128'd0);
    check("round_end",   128'(bus.rk_round), 128'd10);
    check("rk_out_end",  bus.rk_out,         exp_rk[10]);
  endtask

  task automatic idle_check();
    bus.start = 1'b0;
    step();
    check("done_drop",   128'(bus.done),     128'd0);
    check("idle_valid",  128'(bus.rk_valid), 128'd0);
    check("idle_round",  128'(bus.rk_round), 128'd10);
    check("idle_rk_out", bus.rk_out,         exp_rk[10]);
  endtask

  initial begin
    build_tables();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;
    repeat (3) step();
    check("rst_valid",  128'(bus.rk_valid), 128'd0);
    check("rst_busy",   128'(bus.busy),     128'd0);
    check("rst_done",   128'(bus.done),     128'd0);
    check("rst_rk_out", bus.rk_out,         128'd0);
    check("rst_round",  128'(bus.rk_round), 128'd0);
    rst = 1'b0;
    step();

    // FIPS-197 vector at full rate
    run_seq(fips_key, 100, 1'b0, 1'b0);
    check("fips_r1",  got_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    idle_check();

    // all-zero key exercises the 1b/36 rcon wrap
    run_seq(128'd0, 100, 1'b0, 1'b0);
    check("zero_r1",  got_rk[1],  128'h62636363626363636263636362636363);
    check("zero_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    idle_check();

    // backpressure
    run_seq(fips_key, 30, 1'b0, 1'b0);
    idle_check();

    // start pulsed mid-run with another key
    run_seq(fips_key, 100, 1'b0, 1'b1);
    idle_check();

    // reset at round 6
    bus.start    = 1'b1;
    bus.key_in   = fips_key;
    bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    check("pre_rst_round", 128'(bus.rk_round), 128'd6);
    rst = 1'b1;
    step();
    rst          = 1'b0;
    bus.rk_ready = 1'b0;
    check("mid_rst_valid",  128'(bus.rk_valid), 128'd0);
    check("mid_rst_busy",   128'(bus.busy),     128'd0);
    check("mid_rst_done",   128'(bus.done),     128'd0);
    check("mid_rst_rk_out", bus.rk_out,         128'd0);
    check("mid_rst_round",  128'(bus.rk_round), 128'd0);
    repeat (3) begin
      step();
      check("mid_rst_no_done", 128'(bus.done), 128'd0);
    end
    run_seq(rand_key(), 100, 1'b0, 1'b0);

    // back-to-back: zero key started in the done cycle
    bus.start  = 1'b1;
    bus.key_in = 128'd0;
    step();
    run_seq(128'd0, 100, 1'b1, 1'b0);
    check("b2b_r0",  got_rk[0],  128'd0);
    check("b2b_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    idle_check();

    // random keys and random ready duty
    for (int k = 0; k < 8; k++) begin
      run_seq(rand_key(), 20 + int'($urandom_range(80)), 1'b0, 1'b0);
      idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
